// File: rtl/conv_psum_gen.sv
// conv_psum_gen: accumulates KSIZE*KSIZE signed pixel*weight products per output position and
// emits {load_mem, addr, sat16(acc>>>FRAC_BITS)} words. Optional ReLU via `define CONV_PSUM_RELU_EN.
module conv_psum_gen #(
  parameter int unsigned KSIZE     = 3,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [9:0]  out_cols,
  input  logic [9:0]  out_rows,
  input  logic [31:0] row_pitch,
  input  logic        load_mem,
  input  logic        in_valid,
  input  logic [15:0] in_pix,
  input  logic [15:0] in_wgt,
  output logic        in_ready,
  input  logic        STALL,
  output logic        output_valid,
  output logic [48:0] output_value,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TAPS   = KSIZE * KSIZE;
  localparam int unsigned TAP_W  = $clog2(TAPS + 1);
  localparam int unsigned DIM_W  = 10;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned WORD_W = 49;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DIM_W-1:0]        col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]        cols_q, cols_d, rows_q, rows_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d, row_addr_q, row_addr_d;
  logic [ADDR_W-1:0]       pitch_q, pitch_d;
  logic                    load_q, load_d;
  logic                    in_ready_q, in_ready_d;
  logic                    output_valid_q, output_valid_d;
  logic [WORD_W-1:0]       output_value_q, output_value_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [ACC_W-1:0] pix_ext, wgt_ext, prod_c;
  logic [DATA_W-1:0]       data_c;
  logic                    last_col_c, last_row_c;

  // Scale and clamp the accumulator to a signed 16-bit result.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
`ifdef CONV_PSUM_RELU_EN
    s = a[ACC_W-1] ? '0 : (a >>> FRAC_BITS);
`else
    s = a >>> FRAC_BITS;
`endif
    if (s > $signed(32'h0000_7FFF))
      return 16'h7FFF;
    else if (s < $signed(32'hFFFF_8000))
      return 16'h8000;
    else
      return s[DATA_W-1:0];
  endfunction

  always_comb begin
    pix_ext = {{(ACC_W-DATA_W){in_pix[DATA_W-1]}}, in_pix};
    wgt_ext = {{(ACC_W-DATA_W){in_wgt[DATA_W-1]}}, in_wgt};
    prod_c  = pix_ext * wgt_ext;
    data_c  = sat16(acc_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    acc_d          = acc_q;
    col_d          = col_q;
    row_d          = row_q;
    cols_d         = cols_q;
    rows_d         = rows_q;
    cur_addr_d     = cur_addr_q;
    row_addr_d     = row_addr_q;
    pitch_d        = pitch_q;
    load_d         = load_q;
    output_valid_d = 1'b0;
    output_value_d = output_value_q;
    done_d         = 1'b0;
    last_col_c     = (col_q == cols_q - DIM_W'(1));
    last_row_c     = (row_q == rows_q - DIM_W'(1));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cols_d     = out_cols;
          rows_d     = out_rows;
          pitch_d    = row_pitch;
          load_d     = load_mem;
          cur_addr_d = base_addr;
          row_addr_d = base_addr;
          col_d      = '0;
          row_d      = '0;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid && in_ready_q) begin
          acc_d = acc_q + prod_c;
          tap_d = tap_q + TAP_W'(1);
          if (tap_q == TAP_W'(TAPS - 1)) state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!STALL) begin
          output_valid_d = 1'b1;
          output_value_d = {load_q, cur_addr_q, data_c};
          acc_d          = '0;
          tap_d          = '0;
          if (last_col_c) begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_addr_d = row_addr_q + pitch_q;
            cur_addr_d = row_addr_q + pitch_q;
          end else begin
            col_d      = col_q + DIM_W'(1);
            cur_addr_d = cur_addr_q + ADDR_W'(ADDR_STEP);
          end
          state_d = (last_col_c && last_row_c) ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_ACC);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      tap_q          <= '0;
      acc_q          <= '0;
      col_q          <= '0;
      row_q          <= '0;
      cols_q         <= '0;
      rows_q         <= '0;
      cur_addr_q     <= '0;
      row_addr_q     <= '0;
      pitch_q        <= '0;
      load_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      output_valid_q <= 1'b0;
      output_value_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      acc_q          <= acc_d;
      col_q          <= col_d;
      row_q          <= row_d;
      cols_q         <= cols_d;
      rows_q         <= rows_d;
      cur_addr_q     <= cur_addr_d;
      row_addr_q     <= row_addr_d;
      pitch_q        <= pitch_d;
      load_q         <= load_d;
      in_ready_q     <= in_ready_d;
      output_valid_q <= output_valid_d;
      output_value_q <= output_value_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign output_valid = output_valid_q;
  assign output_value = output_value_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_psum_gen.sv
// Testbench for conv_psum_gen: two instances (FRAC_BITS 0 and 8) share stimulus; a scoreboard
// queue holds expected words, checked when output_valid fires. Honours CONV_PSUM_RELU_EN.
module tb_conv_psum_gen;

  typedef struct packed {
    logic [48:0] w0;
    logic [48:0] w8;
  } exp_t;

  typedef struct {
    logic [15:0] pix;
    logic [15:0] wgt;
    logic [15:0] exp0;
    logic [15:0] exp8;
    bit          neg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, load_mem, in_valid, stall;
  logic [31:0] base_addr, row_pitch;
  logic [9:0]  out_cols, out_rows;
  logic [15:0] in_pix, in_wgt;
  logic        rdy0, rdy8, ov0, ov8, busy0, busy8, done0, done8;
  logic [48:0] val0, val8;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  conv_psum_gen #(.KSIZE(3), .FRAC_BITS(0), .ADDR_STEP(1)) u_f0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .out_cols(out_cols),
    .out_rows(out_rows), .row_pitch(row_pitch), .load_mem(load_mem), .in_valid(in_valid),
    .in_pix(in_pix), .in_wgt(in_wgt), .in_ready(rdy0), .STALL(stall),
    .output_valid(ov0), .output_value(val0), .busy(busy0), .done(done0));

  conv_psum_gen #(.KSIZE(3), .FRAC_BITS(8), .ADDR_STEP(1)) u_f8 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .out_cols(out_cols),
    .out_rows(out_rows), .row_pitch(row_pitch), .load_mem(load_mem), .in_valid(in_valid),
    .in_pix(in_pix), .in_wgt(in_wgt), .in_ready(rdy8), .STALL(stall),
    .output_valid(ov8), .output_value(val8), .busy(busy8), .done(done8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_sat(input int acc, input int frac);
    int s;
`ifdef CONV_PSUM_RELU_EN
    if (acc < 0) return 16'h0000;
`endif
    s = acc >>> frac;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  task automatic push_exp(input logic load, input logic [31:0] addr,
                          input logic [15:0] d0, input logic [15:0] d8);
    exp_t e;
    e.w0 = {load, addr, d0};
    e.w8 = {load, addr, d8};
    sb_q.push_back(e);
  endtask

  // Output monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (ov0 || ov8) begin
        check("valid_match", 64'(ov8), 64'(ov0));
        n_valid++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", val0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("word_f0", 64'(val0), 64'(e.w0));
          check("word_f8", 64'(val8), 64'(e.w8));
        end
      end
      if (done0 || done8) begin
        check("done_match", 64'(done8), 64'(done0));
        check("done_after_last", 64'(prev_valid), 64'd1);
      end
    end
    prev_valid = ov0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [31:0] base, input int cols, input int rows,
                            input logic [31:0] pitch, input logic load);
    base_addr = base; out_cols = 10'(cols); out_rows = 10'(rows);
    row_pitch = pitch; load_mem = load; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] p, input logic [15:0] w);
    int guard = 0;
    in_pix = p; in_wgt = w; in_valid = 1'b1;
    while (!rdy0 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done0 && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    tick();
  endtask

  // Full tile with random pairs; optional stall or start/in_valid disturbance at one position.
  task automatic run_tile(input logic [31:0] base, input int cols, input int rows,
                          input logic [31:0] pitch, input logic load,
                          input int stall_at, input int disturb_at);
    int pos = 0;
    start_tile(base, cols, rows, pitch, load);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int acc = 0;
        if (pos == stall_at) stall = 1'b1;
        for (int t = 0; t < 9; t++) begin
          logic [15:0] p, w;
          p = 16'($urandom_range(0, 4000) - 2000);
          w = 16'($urandom_range(0, 4000) - 2000);
          acc += int'($signed(p)) * int'($signed(w));
          send_pair(p, w);
        end
        push_exp(load, base + 32'(r) * pitch + 32'(c), model_sat(acc, 0), model_sat(acc, 8));
        if (pos == stall_at) begin
          for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_no_valid", 64'(ov0), 64'd0);
            check("stall_no_ready", 64'(rdy0), 64'd0);
          end
          stall = 1'b0;
        end
        if (pos == disturb_at) begin
          stall = 1'b1; start = 1'b1; base_addr = 32'hDEAD_0000; out_cols = 10'd7;
          in_valid = 1'b1; in_pix = 16'h7FFF; in_wgt = 16'h7FFF;
          tick();
          start = 1'b0; in_valid = 1'b0;
          tick();
          in_valid = 1'b1;
          tick();
          check("emit_no_ready", 64'(rdy0), 64'd0);
          in_valid = 1'b0; stall = 1'b0;
        end
        pos++;
      end
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; load_mem = 1'b0; in_valid = 1'b0; stall = 1'b0;
    base_addr = '0; row_pitch = '0; out_cols = '0; out_rows = '0; in_pix = '0; in_wgt = '0;

    vecs[0] = '{16'h0002, 16'h0003, 16'h0036, 16'h0000, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h8001, 16'h8000, 16'h8000, 1'b1};
    vecs[3] = '{16'h0100, 16'h0010, 16'h7FFF, 16'h0090, 1'b0};
    vecs[4] = '{16'hFF00, 16'h0010, 16'h8000, 16'hFF70, 1'b1};
    vecs[5] = '{16'hFFFD, 16'h0005, 16'hFF79, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h0064, 16'h0064, 16'h7FFF, 16'h015F, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[8] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};

    tick();
    tick();
    check("rst_busy", 64'({busy0, busy8}), 64'd0);
    check("rst_ready", 64'({rdy0, rdy8}), 64'd0);
    check("rst_valid", 64'({ov0, ov8}), 64'd0);
    check("rst_value", 64'(val0 | val8), 64'd0);
    check("rst_done", 64'({done0, done8}), 64'd0);
    rst = 1'b1;
    tick();

    // Single-position tiles from the vector table.
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d0, d8;
      logic [31:0] base;
      d0 = vecs[i].exp0;
      d8 = vecs[i].exp8;
`ifdef CONV_PSUM_RELU_EN
      if (vecs[i].neg) begin
        d0 = 16'h0000;
        d8 = 16'h0000;
      end
`endif
      base = 32'h100 + 32'(i) * 32'h10;
      start_tile(base, 1, 1, 32'h0, 1'(i));
      check("busy_in_tile", 64'(busy0), 64'd1);
      for (int t = 0; t < 9; t++) send_pair(vecs[i].pix, vecs[i].wgt);
      push_exp(1'(i), base, d0, d8);
      tick();
      check("latency_one", 64'(ov0), 64'd1);
      wait_done();
      check("idle_busy", 64'(busy0), 64'd0);
    end

    // 2x3 tile: address walk and pulse count.
    n_valid = 0;
    run_tile(32'h0, 3, 2, 32'h40, 1'b0, -1, -1);
    check("valid_count", 64'(n_valid), 64'd6);

    // Backpressure during ACC and EMIT.
    run_tile(32'h2000, 2, 1, 32'h10, 1'b1, 0, -1);

    // start and in_valid while in EMIT, then in_valid while IDLE.
    run_tile(32'h3000, 2, 2, 32'h100, 1'b0, -1, 1);
    in_valid = 1'b1; in_pix = 16'h7FFF; in_wgt = 16'h7FFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_no_ready", 64'(rdy0), 64'd0);
    end
    in_valid = 1'b0;
    run_tile(32'h4000, 1, 2, 32'h8, 1'b1, -1, -1);

    // Reset mid-accumulation aborts the tile.
    start_tile(32'h5000, 2, 2, 32'h20, 1'b1);
    for (int t = 0; t < 4; t++) send_pair(16'h1111, 16'h2222);
    rst = 1'b0;
    tick();
    check("abort_busy", 64'({busy0, busy8}), 64'd0);
    check("abort_ready", 64'({rdy0, rdy8}), 64'd0);
    check("abort_valid", 64'({ov0, ov8}), 64'd0);
    check("abort_value", 64'(val0 | val8), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_tile(32'h6000, 2, 2, 32'h20, 1'b0, -1, -1);

    // Address wrap past 2^32.
    run_tile(32'hFFFF_FFFE, 4, 1, 32'h0, 1'b0, -1, -1);

    repeat (5) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
